// File: rtl/c2hdl_call_sequencer_pkg.sv
// Shared types for the c2hdl call sequencer: FSM states and the queued call command.
package c2hdl_seq_pkg;

  localparam int PCW  = 10;
  localparam int TAGW = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LAUNCH,
    RUN,
    HOLD,
    DONE
  } state_t;

  typedef struct packed {
    logic [PCW-1:0]  pc;
    logic [31:0]     ra;
    logic [31:0]     a0;
    logic [TAGW-1:0] tag;
  } cmd_t;

endpackage

// File: rtl/c2hdl_call_sequencer_if.sv
// Command, response and core-handshake signals of the call sequencer.
// master = sequencer side, slave = host glue plus generated core.
interface c2hdl_call_sequencer_if;
  import c2hdl_seq_pkg::*;

  logic            cmd_valid;
  logic            cmd_ready;
  logic [PCW-1:0]  cmd_pc;
  logic [31:0]     cmd_ra;
  logic [31:0]     cmd_a0;
  logic [TAGW-1:0] cmd_tag;
  logic [31:0]     cfg_sp;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [TAGW-1:0] rsp_tag;
  logic [31:0]     rsp_a0;
  logic            rsp_err;

  logic            core_setb;
  logic [PCW-1:0]  core_pc0;
  logic [31:0]     core_ra0;
  logic [31:0]     core_a00;
  logic [31:0]     core_sp0;
  logic            core_idle;
  logic [31:0]     core_ret;

  logic            busy;
  logic [15:0]     calls_done;

  modport master (
    input  cmd_valid, cmd_pc, cmd_ra, cmd_a0, cmd_tag, cfg_sp, rsp_ready, core_idle, core_ret,
    output cmd_ready, rsp_valid, rsp_tag, rsp_a0, rsp_err,
    output core_setb, core_pc0, core_ra0, core_a00, core_sp0, busy, calls_done
  );

  modport slave (
    output cmd_valid, cmd_pc, cmd_ra, cmd_a0, cmd_tag, cfg_sp, rsp_ready, core_idle, core_ret,
    input  cmd_ready, rsp_valid, rsp_tag, rsp_a0, rsp_err,
    input  core_setb, core_pc0, core_ra0, core_a00, core_sp0, busy, calls_done
  );

endinterface

// File: rtl/c2hdl_call_sequencer_fifo.sv
// Synchronous command FIFO (DEPTH a power of two); head visible combinationally on o_dat.
// Caller guarantees no push when full and no pop when empty.
module c2hdl_cmd_fifo
  import c2hdl_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rstb,
  input  logic i_push,
  input  cmd_t i_dat,
  input  logic i_pop,
  output cmd_t o_dat,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          r_mem [DEPTH];
  logic [AW:0]   r_wr;
  logic [AW:0]   r_rd;

  // Pointers carry one extra wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + (AW+1)'(1);
      if (i_pop)  r_rd <= r_rd + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr[AW-1:0]] <= i_dat;
  end

  assign o_dat   = r_mem[r_rd[AW-1:0]];
  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);

endmodule

// File: rtl/c2hdl_call_sequencer.sv
// Queues call commands and runs them one at a time on a c2hdl core via setb/idle; returns a0 + tag.
// Optional per-call watchdog enabled by defining SEQ_TIMEOUT_EN.
module c2hdl_call_sequencer
  import c2hdl_seq_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int SETUP_CYC = 3,
  parameter int HOLD_CYC  = 3
`ifdef SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 2**20
`endif
) (
  input logic                  clk,
  input logic                  rstb,
  c2hdl_call_sequencer_if.master bus
);

  localparam int CNT_MAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  state_t          r_state;
  state_t          w_next;
  logic [CNTW-1:0] r_cnt;
  cmd_t            w_in;
  cmd_t            w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_cap;

  logic [PCW-1:0]  r_pc;
  logic [31:0]     r_ra;
  logic [31:0]     r_a0;
  logic [31:0]     r_sp;
  logic [TAGW-1:0] r_tag;
  logic            r_setb;
  logic            r_rsp_vld;
  logic [TAGW-1:0] r_rsp_tag;
  logic [31:0]     r_rsp_a0;
  logic [15:0]     r_calls_done;

`ifdef SEQ_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0]  r_wd;
  logic            w_tmo;
  logic            r_rsp_err;
`endif

  assign w_in   = '{pc: bus.cmd_pc, ra: bus.cmd_ra, a0: bus.cmd_a0, tag: bus.cmd_tag};
  assign w_push = bus.cmd_valid && !w_full;

  c2hdl_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rstb    (rstb),
    .i_push  (w_push),
    .i_dat   (w_in),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_cap  = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    w_tmo  = 1'b0;
`endif
    case (r_state)
      IDLE:    if (!w_empty && !r_rsp_vld) begin
                 w_next = LOAD;
                 w_pop  = 1'b1;
               end
      LOAD:    if (r_cnt == CNTW'(SETUP_CYC - 1)) w_next = LAUNCH;
      LAUNCH:  if (!bus.core_idle) w_next = RUN;
      RUN:     if (bus.core_idle) begin
                 w_next = HOLD;
                 w_cap  = 1'b1;
               end
      HOLD:    if (r_cnt == CNTW'(HOLD_CYC - 1)) w_next = DONE;
      DONE:    if (bus.rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
`ifdef SEQ_TIMEOUT_EN
    // Watchdog overrides a same-cycle idle rise so the abort is deterministic.
    if ((r_state == LAUNCH || r_state == RUN) && r_wd == WDW'(TIMEOUT_CYC - 1)) begin
      w_next = DONE;
      w_cap  = 1'b0;
      w_tmo  = 1'b1;
    end
`endif
  end

  // setb and rsp_valid follow the next state so they switch with it, glitch-free.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_setb       <= 1'b0;
      r_rsp_vld    <= 1'b0;
      r_calls_done <= '0;
    end else begin
      r_state   <= w_next;
      r_setb    <= (w_next == LAUNCH) || (w_next == RUN) || (w_next == HOLD);
      r_rsp_vld <= (w_next == DONE);
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_state == LOAD || r_state == HOLD)
        r_cnt <= r_cnt + CNTW'(1);
      if (r_state == HOLD && w_next == DONE)
        r_calls_done <= r_calls_done + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_pc  <= '0;
      r_ra  <= '0;
      r_a0  <= '0;
      r_sp  <= '0;
      r_tag <= '0;
    end else if (w_pop) begin
      r_pc  <= w_head.pc;
      r_ra  <= w_head.ra;
      r_a0  <= w_head.a0;
      r_sp  <= bus.cfg_sp;
      r_tag <= w_head.tag;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_rsp_tag <= '0;
      r_rsp_a0  <= '0;
    end else if (w_cap) begin
      r_rsp_tag <= r_tag;
      r_rsp_a0  <= bus.core_ret;
    end
`ifdef SEQ_TIMEOUT_EN
    else if (w_tmo) begin
      r_rsp_tag <= r_tag;
      r_rsp_a0  <= '0;
    end
`endif
  end

`ifdef SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_wd      <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (r_state == LAUNCH || r_state == RUN)
        r_wd <= r_wd + WDW'(1);
      else
        r_wd <= '0;
      if (w_cap)
        r_rsp_err <= 1'b0;
      else if (w_tmo)
        r_rsp_err <= 1'b1;
    end
  end
  assign bus.rsp_err = r_rsp_err;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.cmd_ready  = !w_full;
  assign bus.rsp_valid  = r_rsp_vld;
  assign bus.rsp_tag    = r_rsp_tag;
  assign bus.rsp_a0     = r_rsp_a0;
  assign bus.core_setb  = r_setb;
  assign bus.core_pc0   = r_pc;
  assign bus.core_ra0   = r_ra;
  assign bus.core_a00   = r_a0;
  assign bus.core_sp0   = r_sp;
  assign bus.busy       = (r_state != IDLE) || !w_empty;
  assign bus.calls_done = r_calls_done;

endmodule

// File: tb/tb_c2hdl_call_sequencer.sv
// Directed + randomized bench for c2hdl_call_sequencer with a behavioural core and a call queue model.
module tb_c2hdl_call_sequencer;
  import c2hdl_seq_pkg::*;

  localparam int DEPTH     = 4;
  localparam int SETUP_CYC = 3;
  localparam int HOLD_CYC  = 3;
`ifdef SEQ_TIMEOUT_EN
  localparam int TIMEOUT_CYC = 100;
`endif

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  c2hdl_call_sequencer_if bus ();

  c2hdl_call_sequencer #(
    .DEPTH     (DEPTH),
    .SETUP_CYC (SETUP_CYC),
    .HOLD_CYC  (HOLD_CYC)
`ifdef SEQ_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (TIMEOUT_CYC)
`endif
  ) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus.master)
  );

  int          checks     = 0;
  int          failures   = 0;
  cmd_t        exp_q[$];
  int          exp_done   = 0;
  logic [31:0] cur_sp     = 32'h0;
  int          core_min   = 1;
  int          core_max   = 6;
  bit          core_stuck = 1'b0;
  int          setb_rises = 0;
  bit          saw_full   = 1'b0;

  // What the core is expected to return for a given call.
  function automatic logic [31:0] core_fn(logic [PCW-1:0] pc, logic [31:0] ra, logic [31:0] a0,
                                          logic [31:0] sp);
    return (a0 ^ ra) + 32'(pc) * 32'd40503 + sp;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Behavioural core: starts on setb, runs a random number of cycles, raises idle with a result.
  initial begin : core_model
    int   phase;
    int   rem;
    logic prev;
    phase = 0;
    rem   = 0;
    prev  = 1'b0;
    bus.core_idle = 1'b1;
    bus.core_ret  = '0;
    forever begin
      @(negedge clk);
      if (bus.core_setb && !prev) setb_rises++;
      prev = bus.core_setb;
      if (!bus.core_setb) begin
        phase = 0;
        bus.core_idle = 1'b1;
      end else if (phase == 0) begin
        if (!core_stuck) begin
          bus.core_idle = 1'b0;
          rem   = int'($urandom_range(core_max, core_min));
          phase = 1;
        end
      end else if (phase == 1) begin
        rem--;
        if (rem == 0) begin
          bus.core_idle = 1'b1;
          bus.core_ret  = core_fn(bus.core_pc0, bus.core_ra0, bus.core_a00, bus.core_sp0);
          phase = 2;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: observed=running expected=finished checks=%0d failures=%0d",
             checks, failures);
    $fatal(1, "simulation time limit");
  end

  // Called at a negedge; returns at a negedge after the command was accepted.
  task automatic push_cmd(input cmd_t c);
    int w;
    w = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_pc    = c.pc;
    bus.cmd_ra    = c.ra;
    bus.cmd_a0    = c.a0;
    bus.cmd_tag   = c.tag;
    while (!bus.cmd_ready && w < 2000) begin
      saw_full = 1'b1;
      @(negedge clk);
      w++;
    end
    if (!bus.cmd_ready) chk("push_wait", bus.cmd_ready, 1);
    else begin
      @(posedge clk);
      exp_q.push_back(c);
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
  endtask

  // Waits for a response, checks it against the queue head, holds it for `hold` cycles, accepts it.
  task automatic get_rsp(input int hold);
    int          n;
    int          rises;
    cmd_t        e;
    logic [31:0] ea;
    n = 0;
    while (!bus.rsp_valid && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_valid_seen", bus.rsp_valid, 1);
    chk("rsp_pending", exp_q.size() != 0, 1);
    if (bus.rsp_valid && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      exp_done++;
      ea    = core_fn(e.pc, e.ra, e.a0, cur_sp);
      rises = setb_rises;
      for (int i = 0; i <= hold; i++) begin
        chk("rsp_valid_hold", bus.rsp_valid, 1);
        chk("rsp_tag", bus.rsp_tag, e.tag);
        chk("rsp_a0", bus.rsp_a0, ea);
        chk("rsp_err", bus.rsp_err, 0);
        chk("setb_low_in_done", bus.core_setb, 0);
        if (hold > 0) chk("no_new_call", setb_rises, rises);
        if (i < hold) @(negedge clk);
      end
      chk("calls_done", bus.calls_done, 16'(exp_done));
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
    end
  endtask

  initial begin : stim
    cmd_t c;
    int   k;
    int   n;
    int   rises;
    bus.cmd_valid = 1'b0;
    bus.cmd_pc    = '0;
    bus.cmd_ra    = '0;
    bus.cmd_a0    = '0;
    bus.cmd_tag   = '0;
    bus.rsp_ready = 1'b0;
    cur_sp        = 32'h0000_8000;
    bus.cfg_sp    = cur_sp;

    // Reset state.
    #1;
    chk("rst_setb", bus.core_setb, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_calls_done", bus.calls_done, 0);
    chk("rst_rsp_a0", bus.rsp_a0, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_core_pc0", bus.core_pc0, 0);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);

    // 1: single call, core busy 20 cycles; latency and setb window.
    core_min = 20;
    core_max = 20;
    c = '{pc: '0, ra: 32'h44, a0: 32'h1000, tag: 4'h5};
    bus.cmd_valid = 1'b1;
    bus.cmd_pc = c.pc; bus.cmd_ra = c.ra; bus.cmd_a0 = c.a0; bus.cmd_tag = c.tag;
    @(posedge clk); #1;
    exp_q.push_back(c);
    bus.cmd_valid = 1'b0;
    k = 1;
    while (!bus.core_setb && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t1_latency", k, SETUP_CYC + 2);
    chk("t1_pc0", bus.core_pc0, 0);
    chk("t1_ra0", bus.core_ra0, 32'h44);
    chk("t1_a00", bus.core_a00, 32'h1000);
    chk("t1_sp0", bus.core_sp0, cur_sp);
    chk("t1_busy", bus.busy, 1);
    n = 0;
    while (bus.core_setb && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    chk("t1_setb_cycles", n, 20 + HOLD_CYC + 1);
    @(negedge clk);
    get_rsp(0);

    // 2: 75 back-to-back calls through a 4-deep FIFO.
    core_min = 1;
    core_max = 6;
    cur_sp = $urandom;
    bus.cfg_sp = cur_sp;
    saw_full = 1'b0;
    fork
      begin
        cmd_t p;
        for (int i = 0; i < 75; i++) begin
          p = '{pc: '0, ra: $urandom, a0: $urandom, tag: TAGW'(i)};
          push_cmd(p);
        end
      end
      begin
        for (int j = 0; j < 75; j++) get_rsp(0);
      end
    join
    chk("t2_backpressure", saw_full, 1);
    chk("t2_calls_done", bus.calls_done, 16'd76);
    chk("t2_idle_busy", bus.busy, 0);

    // 3: response held 50 cycles while another call waits in the FIFO.
    for (int i = 0; i < 2; i++) begin
      c = '{pc: PCW'($urandom), ra: $urandom, a0: $urandom, tag: TAGW'($urandom)};
      push_cmd(c);
    end
    get_rsp(50);
    rises = setb_rises;
    get_rsp(0);
    chk("t3_second_launch", setb_rises, rises + 1);

    // 4: reset during RUN discards the queue and drops setb immediately.
    core_min = 30;
    core_max = 30;
    for (int i = 0; i < 2; i++) begin
      c = '{pc: PCW'($urandom), ra: $urandom, a0: $urandom, tag: TAGW'(i)};
      push_cmd(c);
    end
    n = 0;
    do begin
      @(negedge clk); #2;
      n++;
    end while (!(bus.core_setb && !bus.core_idle) && n < 500);
    chk("t4_in_run", bus.core_setb && !bus.core_idle, 1);
    rstb = 1'b0;
    #1;
    chk("t4_setb", bus.core_setb, 0);
    chk("t4_rsp_valid", bus.rsp_valid, 0);
    chk("t4_busy", bus.busy, 0);
    chk("t4_cmd_ready", bus.cmd_ready, 1);
    chk("t4_calls_done", bus.calls_done, 0);
    exp_q.delete();
    exp_done = 0;
    @(negedge clk);
    rstb = 1'b1;
    rises = setb_rises;
    repeat (20) @(negedge clk);
    chk("t4_no_restart", setb_rises, rises);
    chk("t4_busy_after", bus.busy, 0);

    // Normal call after reset recovery.
    core_min = 1;
    core_max = 6;
    c = '{pc: PCW'($urandom), ra: $urandom, a0: $urandom, tag: 4'hA};
    push_cmd(c);
    get_rsp(0);

`ifdef SEQ_TIMEOUT_EN
    // 5: stuck core aborted by the watchdog, then a normal call proceeds.
    core_stuck = 1'b1;
    c = '{pc: PCW'($urandom), ra: $urandom, a0: $urandom, tag: 4'h3};
    push_cmd(c);
    n = 0;
    while (!bus.core_setb && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    k = 0;
    n = 0;
    while (!bus.rsp_valid && n < 300) begin
      if (bus.core_setb) k++;
      @(posedge clk); #1;
      n++;
    end
    chk("t5_setb_cycles", k, TIMEOUT_CYC);
    chk("t5_rsp_valid", bus.rsp_valid, 1);
    chk("t5_rsp_err", bus.rsp_err, 1);
    chk("t5_rsp_a0", bus.rsp_a0, 0);
    chk("t5_rsp_tag", bus.rsp_tag, 4'h3);
    chk("t5_calls_done", bus.calls_done, 16'(exp_done));
    chk("t5_setb", bus.core_setb, 0);
    void'(exp_q.pop_front());
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    core_stuck = 1'b0;
    c = '{pc: PCW'($urandom), ra: $urandom, a0: $urandom, tag: 4'h4};
    push_cmd(c);
    get_rsp(0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
